// File: rtl/lcd_bus_scheduler.sv
// Two-port round-robin scheduler for a write-only character-LCD bus.
// Each accepted request becomes one setup / enable pulse / hold / settle write sequence.
module lcd_bus_scheduler #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 1,
    parameter int unsigned SHORT_WAIT   = 4,
    parameter int unsigned LONG_WAIT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] lcd_data,
    output logic       lcd_enable,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic       busy,
    output logic       last_grant
);

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] SHORT_LD = 8'(SHORT_WAIT - 1);
    localparam logic [7:0] LONG_LD  = 8'(LONG_WAIT - 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       long_q;
    logic       open;
    logic       sel;
    logic       accept;
    logic       pick_rs;
    logic [7:0] pick_data;
    logic       pick_long;

    // The last settle cycle is treated as the IDLE return so a waiting
    // request is taken on the same edge the write finishes.
    assign open = (state == IDLE) || ((state == WAIT) && (cnt == 8'd0));

    always_comb begin
        sel = ~last_grant;
        if (req0_valid && !req1_valid)
            sel = 1'b0;
        else if (req1_valid && !req0_valid)
            sel = 1'b1;
    end

    assign req0_ready = open && !sel;
    assign req1_ready = open && sel;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign pick_rs    = sel ? req1_rs : req0_rs;
    assign pick_data  = sel ? req1_data : req0_data;
    // Clear display (0x01) and return home (0x02/0x03) need the long settle.
    assign pick_long  = !pick_rs && (pick_data[7:2] == 6'd0) && (pick_data[1:0] != 2'd0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SETUP;
                    cnt_nx   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_nx = PULSE;
                    cnt_nx   = PULSE_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            PULSE: begin
                if (cnt == 8'd0) begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    state_nx = WAIT;
                    cnt_nx   = long_q ? LONG_LD : SHORT_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            WAIT: begin
                if (cnt == 8'd0) begin
                    if (accept) begin
                        state_nx = SETUP;
                        cnt_nx   = SETUP_LD;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            lcd_data   <= 8'h00;
            lcd_rs     <= 1'b0;
            lcd_enable <= 1'b0;
            long_q     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            // Registered strobe keeps the enable pin free of decode glitches.
            lcd_enable <= (state_nx == PULSE);
            if (accept) begin
                lcd_data   <= pick_data;
                lcd_rs     <= pick_rs;
                long_q     <= pick_long;
                last_grant <= sel;
            end
        end
    end

    assign busy   = (state != IDLE);
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Scoreboard bench for lcd_bus_scheduler: stimulus queues expected accepts,
// a negedge monitor checks grant order, spacing, strobe and bus values each cycle.
module tb_lcd_bus_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid, req0_rs, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_rs, req1_ready;
    logic [7:0] req1_data;
    logic [7:0] lcd_data;
    logic       lcd_enable, lcd_rw, lcd_rs, busy, last_grant;

    always #5 clk = ~clk;

    lcd_bus_scheduler dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .lcd_data(lcd_data), .lcd_enable(lcd_enable), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs),
        .busy(busy), .last_grant(last_grant)
    );

    typedef struct {
        bit         port;
        bit         rs;
        logic [7:0] data;
        int         gap;   // expected cycles since previous accept, 0 = don't care
        int         len;   // expected busy length of this write
    } exp_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } req_t;

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit port, input bit rs, input logic [7:0] d, input int gap, input int len);
        exp_t e;
        e.port = port; e.rs = rs; e.data = d; e.gap = gap; e.len = len;
        sb.push_back(e);
        if (port) q1.push_back({rs, d});
        else      q0.push_back({rs, d});
    endtask

    // Driver: presents the head of each port queue, pops it once accepted.
    initial begin
        bit   t0, t1;
        req_t dummy;
        req0_valid = 0; req0_rs = 0; req0_data = 8'hA5;
        req1_valid = 0; req1_rs = 0; req1_data = 8'h5A;
        forever begin
            @(negedge clk);
            t0 = req0_valid && req0_ready && !rst;
            t1 = req1_valid && req1_ready && !rst;
            @(posedge clk);
            #1;
            if (t0) dummy = q0.pop_front();
            if (t1) dummy = q1.pop_front();
            req0_valid = (q0.size() > 0);
            if (q0.size() > 0) {req0_rs, req0_data} = q0[0];
            else req0_data = 8'hA5;
            req1_valid = (q1.size() > 0);
            if (q1.size() > 0) {req1_rs, req1_data} = q1[0];
            else req1_data = 8'h5A;
        end
    end

    // Monitor: applies events seen at the previous negedge, then checks outputs.
    bit         started = 0, pend_rst = 0, pend_acc = 0, pend_port = 0, act = 0;
    int         a = 0, len = 8, last_a = -1000;
    logic [7:0] e_data = 8'h00;
    logic       e_rs = 0, e_lg = 1;
    exp_t       e_cur;

    always @(negedge clk) begin
        cyc++;
        if (pend_rst) begin
            started = 1; act = 0; e_data = 8'h00; e_rs = 0; e_lg = 1;
        end else if (pend_acc) begin
            if (sb.size() == 0) begin
                chk("unexpected_accept", 32'(pend_port), 32'hFF);
                len = 8;
            end else begin
                e_cur = sb.pop_front();
                chk("grant_port", 32'(pend_port), 32'(e_cur.port));
                if (e_cur.gap != 0) chk("accept_gap", 32'(cyc - last_a), 32'(e_cur.gap));
                e_data = e_cur.data; e_rs = e_cur.rs; e_lg = e_cur.port; len = e_cur.len;
            end
            act = 1; a = cyc; last_a = cyc;
        end else if (act && cyc >= a + len) begin
            act = 0;
        end
        if (started) begin
            chk("lcd_data", 32'(lcd_data), 32'(e_data));
            chk("lcd_rs", 32'(lcd_rs), 32'(e_rs));
            chk("lcd_enable", 32'(lcd_enable), 32'(act && (cyc == a + 1 || cyc == a + 2)));
            chk("busy", 32'(busy), 32'(act));
            chk("lcd_rw", 32'(lcd_rw), 32'h0);
            chk("last_grant", 32'(last_grant), 32'(e_lg));
            if (!rst) chk("ready_onehot", 32'(req0_ready && req1_ready), 32'h0);
        end
        pend_rst  = rst;
        pend_acc  = !rst && ((req0_valid && req0_ready) || (req1_valid && req1_ready));
        pend_port = req1_valid && req1_ready;
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && !busy) && n < 500);
        if (n >= 500) chk("idle_timeout", 32'(n), 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
    endtask

    initial begin
        int n;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Data write, next request queued while busy: 8-cycle spacing.
        push(0, 1, 8'h48, 0, 8);
        push(0, 1, 8'h49, 8, 8);
        wait_idle();

        // Instruction settle selection, including 0x00/0x04 boundaries and rs=1 0x01.
        push(0, 0, 8'h01, 0, 20);
        push(0, 0, 8'h00, 20, 8);
        push(0, 0, 8'h04, 8, 8);
        push(0, 0, 8'h03, 8, 20);
        push(0, 1, 8'h01, 20, 8);
        push(0, 0, 8'h41, 8, 8);
        wait_idle();

        // Contention after reset: port 0 first, then strict alternation.
        pulse_rst();
        push(0, 1, 8'h30, 0, 8);
        push(1, 1, 8'h41, 8, 8);
        push(0, 1, 8'h31, 8, 8);
        push(1, 1, 8'h42, 8, 8);
        push(0, 1, 8'h32, 8, 8);
        push(1, 1, 8'h43, 8, 8);
        wait_idle();

        // Port 1 alone, back-to-back.
        push(1, 1, 8'h61, 0, 8);
        push(1, 1, 8'h62, 8, 8);
        push(1, 1, 8'h63, 8, 8);
        wait_idle();

        // Reset while enable is high, then contention resolves to port 0.
        push(0, 1, 8'h55, 0, 8);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!lcd_enable && n < 50);
        if (n >= 50) chk("enable_timeout", 32'(n), 32'h0);
        pulse_rst();
        push(0, 1, 8'h70, 0, 8);
        push(1, 1, 8'h71, 8, 8);
        wait_idle();

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
